// File: rtl/ysyx_22050710_trap_pkg.sv
// Shared constants and types for the machine-mode trap unit.
package ysyx_22050710_trap_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_EBREAK  = 4'd3;
  localparam logic [3:0] CAUSE_ECALL   = 4'd11;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LO   = 11;
  localparam int MSTATUS_MPP_HI   = 12;

  typedef enum logic {
    ST_IDLE,
    ST_REDIRECT
  } trapState_e;

  // Interrupt line k reports cause code 4k+3 (software/timer/external/...)
  function automatic logic [3:0] irqCode(input int k);
    return 4'(4 * k + 3);
  endfunction

  // Bit position of line k inside mie/mip
  function automatic int irqBit(input int k);
    return 4 * k + 3;
  endfunction

endpackage

// File: rtl/ysyx_22050710_trap_if.sv
// Bundle of ID-side trap request, CSR access and fetch redirect signals.
interface ysyx_22050710_trap_if #(
  parameter int PC_WD   = 64,
  parameter int CSR_WD  = 64,
  parameter int IRQ_NUM = 3
);
  logic               i_req_valid;
  logic               o_req_ready;
  logic [PC_WD-1:0]   i_pc;
  logic               i_ecall_sel;
  logic               i_ebreak_sel;
  logic               i_illegal_sel;
  logic               i_mret_sel;
  logic [IRQ_NUM-1:0] i_irq;
  logic               i_csr_we;
  logic [11:0]        i_csr_addr;
  logic [CSR_WD-1:0]  i_csr_wdata;
  logic [CSR_WD-1:0]  o_csr_rdata;
  logic               o_redirect_valid;
  logic [PC_WD-1:0]   o_redirect_pc;
  logic               i_redirect_ready;
  logic               o_flush;

  modport slave (
    input  i_req_valid, i_pc, i_ecall_sel, i_ebreak_sel, i_illegal_sel, i_mret_sel,
    input  i_irq, i_csr_we, i_csr_addr, i_csr_wdata, i_redirect_ready,
    output o_req_ready, o_csr_rdata, o_redirect_valid, o_redirect_pc, o_flush
  );

  modport master (
    output i_req_valid, i_pc, i_ecall_sel, i_ebreak_sel, i_illegal_sel, i_mret_sel,
    output i_irq, i_csr_we, i_csr_addr, i_csr_wdata, i_redirect_ready,
    input  o_req_ready, o_csr_rdata, o_redirect_valid, o_redirect_pc, o_flush
  );
endinterface

// File: rtl/ysyx_22050710_irq_arbiter.sv
// Masks the interrupt lines with mie and the global enable, picks the winner.
module ysyx_22050710_irq_arbiter
  import ysyx_22050710_trap_pkg::*;
#(
  parameter int IRQ_NUM = 3
) (
  input  logic [IRQ_NUM-1:0] irq_i,
  input  logic [IRQ_NUM-1:0] mie_i,
  input  logic               mstatusMie_i,
  output logic               take_o,
  output logic [3:0]         code_o
);

  // Scan upward so the highest-numbered enabled line overwrites lower ones
  always_comb begin
    take_o = 1'b0;
    code_o = 4'd0;
    for (int k = 0; k < IRQ_NUM; k++) begin
      if (mstatusMie_i && irq_i[k] && mie_i[k]) begin
        take_o = 1'b1;
        code_o = irqCode(k);
      end
    end
  end

endmodule

// File: rtl/ysyx_22050710_trap_unit.sv
// Machine-mode trap unit: trap CSRs, trap/mret arbitration, fetch redirect.
module ysyx_22050710_trap_unit
  import ysyx_22050710_trap_pkg::*;
#(
  parameter int                PC_WD     = 64,
  parameter int                CSR_WD    = 64,
  parameter int                IRQ_NUM   = 3,
  parameter logic [CSR_WD-1:0] MTVEC_RST = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  ysyx_22050710_trap_if.slave   bus
);

  trapState_e         state_q, state_d;
  logic               mie_q, mie_d;
  logic               mpie_q, mpie_d;
  logic [IRQ_NUM-1:0] mieBits_q, mieBits_d;
  logic [CSR_WD-1:0]  mtvec_q, mtvec_d;
  logic [CSR_WD-1:0]  mepc_q, mepc_d;
  logic [CSR_WD-1:0]  mcause_q, mcause_d;
  logic [PC_WD-1:0]   redirPc_q, redirPc_d;

  logic               irqTake;
  logic [3:0]         winCode;
  logic               take;
  logic               accept;
  logic               trapEntry;
  logic               doMret;
  logic [3:0]         excCode;
  logic [CSR_WD-1:0]  trapBase;
  logic [CSR_WD-1:0]  trapTarget;

  ysyx_22050710_irq_arbiter #(.IRQ_NUM(IRQ_NUM)) u_arbiter (
    .irq_i        (bus.i_irq),
    .mie_i        (mieBits_q),
    .mstatusMie_i (mie_q),
    .take_o       (irqTake),
    .code_o       (winCode)
  );

  // Decide whether this boundary traps and which source wins
  always_comb begin
    take      = irqTake | bus.i_illegal_sel | bus.i_ebreak_sel | bus.i_ecall_sel | bus.i_mret_sel;
    accept    = bus.i_req_valid & (state_q == ST_IDLE) & take;
    trapEntry = accept & (irqTake | bus.i_illegal_sel | bus.i_ebreak_sel | bus.i_ecall_sel);
    doMret    = accept & ~trapEntry;
    excCode   = CAUSE_ECALL;
    if (bus.i_ebreak_sel)  excCode = CAUSE_EBREAK;
    if (bus.i_illegal_sel) excCode = CAUSE_ILLEGAL;
    trapBase  = {mtvec_q[CSR_WD-1:2], 2'b00};
    if (irqTake && (mtvec_q[1:0] == 2'b01)) begin
      trapTarget = trapBase + (CSR_WD'(winCode) << 2);
    end else begin
      trapTarget = trapBase;
    end
  end

  // Next CSR contents: software write first, trap side effects override it
  always_comb begin
    mie_d     = mie_q;
    mpie_d    = mpie_q;
    mieBits_d = mieBits_q;
    mtvec_d   = mtvec_q;
    mepc_d    = mepc_q;
    mcause_d  = mcause_q;
    if (bus.i_csr_we) begin
      case (bus.i_csr_addr)
        CSR_MSTATUS: begin
          mie_d  = bus.i_csr_wdata[MSTATUS_MIE_BIT];
          mpie_d = bus.i_csr_wdata[MSTATUS_MPIE_BIT];
        end
        CSR_MIE: begin
          for (int k = 0; k < IRQ_NUM; k++) mieBits_d[k] = bus.i_csr_wdata[irqBit(k)];
        end
        CSR_MTVEC:  mtvec_d  = bus.i_csr_wdata;
        CSR_MEPC:   mepc_d   = {bus.i_csr_wdata[CSR_WD-1:1], 1'b0};
        CSR_MCAUSE: mcause_d = bus.i_csr_wdata;
        default: ;
      endcase
    end
    if (trapEntry) begin
      mepc_d              = CSR_WD'(bus.i_pc & ~PC_WD'(1));
      mcause_d            = '0;
      mcause_d[CSR_WD-1]  = irqTake;
      mcause_d[3:0]       = irqTake ? winCode : excCode;
      mpie_d              = mie_q;
      mie_d               = 1'b0;
    end else if (doMret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end
  end

  // Capture the redirect target on the accept edge, hold it otherwise
  always_comb begin
    redirPc_d = redirPc_q;
    if (trapEntry) begin
      redirPc_d = trapTarget[PC_WD-1:0];
    end else if (doMret) begin
      redirPc_d = mepc_q[PC_WD-1:0];
    end
  end

  // Next state: leave IDLE on accept, return once fetch takes the redirect
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (accept) state_d = ST_REDIRECT;
      ST_REDIRECT: if (bus.i_redirect_ready) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Outputs driven from state, flush is the combinational accept pulse
  always_comb begin
    bus.o_req_ready      = (state_q == ST_IDLE);
    bus.o_redirect_valid = (state_q == ST_REDIRECT);
    bus.o_flush          = accept;
    bus.o_redirect_pc    = redirPc_q;
  end

  // CSR read port shows the pre-edge register values
  always_comb begin
    bus.o_csr_rdata = '0;
    case (bus.i_csr_addr)
      CSR_MSTATUS: begin
        bus.o_csr_rdata[MSTATUS_MIE_BIT]                = mie_q;
        bus.o_csr_rdata[MSTATUS_MPIE_BIT]               = mpie_q;
        bus.o_csr_rdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
      end
      CSR_MIE: begin
        for (int k = 0; k < IRQ_NUM; k++) bus.o_csr_rdata[irqBit(k)] = mieBits_q[k];
      end
      CSR_MIP: begin
        for (int k = 0; k < IRQ_NUM; k++) bus.o_csr_rdata[irqBit(k)] = bus.i_irq[k];
      end
      CSR_MTVEC:  bus.o_csr_rdata = mtvec_q;
      CSR_MEPC:   bus.o_csr_rdata = mepc_q;
      CSR_MCAUSE: bus.o_csr_rdata = mcause_q;
      default: ;
    endcase
  end

  // State and CSR registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      mie_q     <= 1'b0;
      mpie_q    <= 1'b0;
      mieBits_q <= '0;
      mtvec_q   <= MTVEC_RST;
      mepc_q    <= '0;
      mcause_q  <= '0;
      redirPc_q <= '0;
    end else begin
      state_q   <= state_d;
      mie_q     <= mie_d;
      mpie_q    <= mpie_d;
      mieBits_q <= mieBits_d;
      mtvec_q   <= mtvec_d;
      mepc_q    <= mepc_d;
      mcause_q  <= mcause_d;
      redirPc_q <= redirPc_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22050710_trap_unit.sv
// Randomized plus directed bench for the trap unit against a behavioural model.
module tb_ysyx_22050710_trap_unit;

  localparam int          TB_IRQ  = 3;
  localparam logic [63:0] RST_VEC = 64'h0000_0000_2000_0004;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ysyx_22050710_trap_if #(.PC_WD(64), .CSR_WD(64), .IRQ_NUM(TB_IRQ)) bus ();

  ysyx_22050710_trap_unit #(
    .PC_WD(64), .CSR_WD(64), .IRQ_NUM(TB_IRQ), .MTVEC_RST(RST_VEC)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic              mMie, mMpie;
  logic [TB_IRQ-1:0] mMieBits;
  logic [63:0]       mMtvec, mMepc, mMcause, mRedirPc;
  bit                mBusy;

  logic [11:0] addrs [7] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h7c0};

  // Count one comparison and report it when it disagrees
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model state after reset
  task automatic mdlReset();
    mMie = 0; mMpie = 0; mMieBits = '0;
    mMtvec = RST_VEC; mMepc = 0; mMcause = 0;
    mRedirPc = 0; mBusy = 0;
  endtask

  // Idle all driven inputs
  task automatic clearInputs();
    bus.i_req_valid = 0; bus.i_pc = '0;
    bus.i_ecall_sel = 0; bus.i_ebreak_sel = 0; bus.i_illegal_sel = 0; bus.i_mret_sel = 0;
    bus.i_irq = '0; bus.i_csr_we = 0; bus.i_csr_addr = '0; bus.i_csr_wdata = '0;
    bus.i_redirect_ready = 0;
  endtask

  // Highest pending enabled line, or -1 when nothing may interrupt
  function automatic int mdlIrqWinner();
    if (!mMie) return -1;
    for (int k = TB_IRQ - 1; k >= 0; k--)
      if (bus.i_irq[k] && mMieBits[k]) return k;
    return -1;
  endfunction

  // Architectural CSR view
  function automatic logic [63:0] mdlRead(input logic [11:0] a);
    logic [63:0] r;
    r = 0;
    case (a)
      12'h300: begin r = 64'h1800; r[3] = mMie; r[7] = mMpie; end
      12'h304: for (int k = 0; k < TB_IRQ; k++) r[4*k+3] = mMieBits[k];
      12'h344: for (int k = 0; k < TB_IRQ; k++) r[4*k+3] = bus.i_irq[k];
      12'h305: r = mMtvec;
      12'h341: r = mMepc;
      12'h342: r = mMcause;
      default: r = 0;
    endcase
    return r;
  endfunction

  // Check outputs for the current inputs, clock once, advance the model
  task automatic applyStimulus();
    int win;
    bit exc, acc;
    logic [3:0] code;
    logic [63:0] base, oldMtvec, oldMepc;
    logic oldMie, oldMpie;
    #1;
    win = mdlIrqWinner();
    exc = bus.i_illegal_sel || bus.i_ebreak_sel || bus.i_ecall_sel;
    acc = bus.i_req_valid && !mBusy && (win >= 0 || exc || bus.i_mret_sel);
    checkOutput("ready",  64'(bus.o_req_ready), 64'(!mBusy));
    checkOutput("flush",  64'(bus.o_flush), 64'(acc));
    checkOutput("rvalid", 64'(bus.o_redirect_valid), 64'(mBusy));
    if (mBusy) checkOutput("rpc", bus.o_redirect_pc, mRedirPc);
    checkOutput("rdata", bus.o_csr_rdata, mdlRead(bus.i_csr_addr));
    @(posedge clk);
    oldMie = mMie; oldMpie = mMpie; oldMtvec = mMtvec; oldMepc = mMepc;
    if (bus.i_csr_we) begin
      case (bus.i_csr_addr)
        12'h300: begin mMie = bus.i_csr_wdata[3]; mMpie = bus.i_csr_wdata[7]; end
        12'h304: for (int k = 0; k < TB_IRQ; k++) mMieBits[k] = bus.i_csr_wdata[4*k+3];
        12'h305: mMtvec = bus.i_csr_wdata;
        12'h341: mMepc = bus.i_csr_wdata & ~64'h1;
        12'h342: mMcause = bus.i_csr_wdata;
        default: ;
      endcase
    end
    if (acc) begin
      mBusy = 1;
      if (win >= 0 || exc) begin
        if (win >= 0) code = 4'(4 * win + 3);
        else if (bus.i_illegal_sel) code = 4'd2;
        else if (bus.i_ebreak_sel) code = 4'd3;
        else code = 4'd11;
        mMepc = bus.i_pc & ~64'h1;
        mMcause = 64'(code);
        mMcause[63] = (win >= 0);
        mMpie = oldMie;
        mMie = 0;
        base = oldMtvec & ~64'h3;
        mRedirPc = (win >= 0 && oldMtvec[1:0] == 2'b01) ? base + 64'(code) * 4 : base;
      end else begin
        mMie = oldMpie;
        mMpie = 1;
        mRedirPc = oldMepc;
      end
    end else if (mBusy && bus.i_redirect_ready) begin
      mBusy = 0;
    end
    #1;
  endtask

  task automatic csrWrite(input logic [11:0] a, input logic [63:0] d);
    clearInputs();
    bus.i_csr_we = 1; bus.i_csr_addr = a; bus.i_csr_wdata = d;
    applyStimulus();
    clearInputs();
  endtask

  task automatic readCsr(input logic [11:0] a, input logic rdy);
    clearInputs();
    bus.i_csr_addr = a; bus.i_redirect_ready = rdy;
    applyStimulus();
  endtask

  // Directed scenarios followed by a randomized run
  initial begin
    clearInputs();
    mdlReset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    readCsr(12'h305, 0);
    readCsr(12'h300, 0);
    readCsr(12'h341, 0);

    $display("[TB] ecall with direct mtvec");
    csrWrite(12'h300, 64'h8);
    csrWrite(12'h305, 64'h8000_0000);
    clearInputs();
    bus.i_req_valid = 1; bus.i_ecall_sel = 1; bus.i_pc = 64'h8000_0100; bus.i_csr_addr = 12'h341;
    applyStimulus();
    readCsr(12'h341, 0);
    readCsr(12'h342, 1);
    readCsr(12'h300, 0);

    $display("[TB] mret with fetch stalled");
    clearInputs();
    bus.i_req_valid = 1; bus.i_mret_sel = 1;
    applyStimulus();
    for (int i = 0; i < 3; i++) begin
      clearInputs();
      bus.i_req_valid = 1; bus.i_ecall_sel = 1; bus.i_pc = 64'h1234;
      applyStimulus();
    end
    readCsr(12'h300, 1);
    readCsr(12'h300, 0);

    $display("[TB] vectored interrupt");
    csrWrite(12'h305, 64'h8000_0001);
    csrWrite(12'h300, 64'h8);
    csrWrite(12'h304, 64'h888);
    clearInputs();
    bus.i_irq = 3'b110; bus.i_csr_addr = 12'h344;
    applyStimulus();
    bus.i_req_valid = 1; bus.i_pc = 64'h4000_0006;
    applyStimulus();
    clearInputs();
    bus.i_irq = 3'b001; bus.i_csr_addr = 12'h304;
    applyStimulus();
    readCsr(12'h342, 1);
    readCsr(12'h341, 0);

    $display("[TB] exception priority");
    clearInputs();
    bus.i_req_valid = 1; bus.i_ecall_sel = 1; bus.i_illegal_sel = 1; bus.i_pc = 64'h200;
    applyStimulus();
    readCsr(12'h342, 1);
    clearInputs();
    bus.i_req_valid = 1; bus.i_ecall_sel = 1; bus.i_mret_sel = 1; bus.i_pc = 64'h300;
    applyStimulus();
    readCsr(12'h342, 1);
    readCsr(12'h300, 0);

    $display("[TB] CSR write colliding with trap");
    clearInputs();
    bus.i_req_valid = 1; bus.i_ecall_sel = 1; bus.i_pc = 64'h400;
    bus.i_csr_we = 1; bus.i_csr_addr = 12'h300; bus.i_csr_wdata = 64'h88;
    applyStimulus();
    readCsr(12'h300, 1);
    csrWrite(12'h300, 64'h8);
    clearInputs();
    bus.i_req_valid = 1; bus.i_ebreak_sel = 1; bus.i_pc = 64'h500;
    bus.i_csr_we = 1; bus.i_csr_addr = 12'h300; bus.i_csr_wdata = 64'h0;
    applyStimulus();
    readCsr(12'h300, 1);

    $display("[TB] randomized run");
    for (int i = 0; i < 400; i++) begin
      bus.i_req_valid      = 1'($urandom_range(0, 1));
      bus.i_ecall_sel      = ($urandom_range(0, 5) == 0);
      bus.i_ebreak_sel     = ($urandom_range(0, 5) == 0);
      bus.i_illegal_sel    = ($urandom_range(0, 5) == 0);
      bus.i_mret_sel       = ($urandom_range(0, 5) == 0);
      bus.i_irq            = 3'($urandom_range(0, 7));
      bus.i_csr_we         = ($urandom_range(0, 3) == 0);
      bus.i_csr_addr       = addrs[$urandom_range(0, 6)];
      bus.i_csr_wdata      = {$urandom, $urandom};
      bus.i_pc             = {$urandom, $urandom};
      bus.i_redirect_ready = 1'($urandom_range(0, 1));
      applyStimulus();
    end

    $display("[TB] reset during redirect");
    readCsr(12'h300, 1);
    readCsr(12'h300, 1);
    clearInputs();
    bus.i_req_valid = 1; bus.i_ecall_sel = 1; bus.i_pc = 64'h600;
    applyStimulus();
    clearInputs();
    bus.i_csr_addr = 12'h305;
    rst = 1;
    #1;
    checkOutput("rst_rvalid", 64'(bus.o_redirect_valid), 64'h0);
    checkOutput("rst_ready",  64'(bus.o_req_ready), 64'h1);
    checkOutput("rst_rpc",    bus.o_redirect_pc, 64'h0);
    checkOutput("rst_mtvec",  bus.o_csr_rdata, RST_VEC);
    mdlReset();
    @(posedge clk);
    #2 rst = 0;
    readCsr(12'h305, 0);
    readCsr(12'h342, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_22050710_trap_unit.md
# ysyx_22050710_trap_unit

Parametrised machine-mode trap unit for the ID stage. Owns the trap CSRs (mstatus.MIE/MPIE, mie, mip, mtvec, mepc, mcause), arbitrates ecall/ebreak/illegal/mret and up to four level-sensitive interrupt lines, and updates CSR state on the trap edge. Issues a registered PC redirect to fetch under a valid/ready handshake, with direct and vectored mtvec modes.

## Interface
- PC_WD, 64, PC width
- CSR_WD, 64, CSR width; PC_WD ≤ CSR_WD
- IRQ_NUM, 3, interrupt lines, 1..4; line k has cause code 4k+3 (3/7/11/15)
- MTVEC_RST, 0, mtvec reset value
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_req_valid  in  1  ID presents an instruction boundary (valid instruction at i_pc)
- o_req_ready  out  1  unit can accept a trap this cycle
- i_pc  in  PC_WD  PC of instruction in ID
- i_ecall_sel / i_ebreak_sel / i_illegal_sel / i_mret_sel  in  1 each  decoded trap kind
- i_irq  in  IRQ_NUM  level interrupt lines
- i_csr_we  in  1  CSR write strobe
- i_csr_addr  in  12  CSR address, read and write
- i_csr_wdata  in  CSR_WD  write data
- o_csr_rdata  out  CSR_WD  combinational read data
- o_redirect_valid  out  1  redirect PC valid
- o_redirect_pc  out  PC_WD  redirect target
- i_redirect_ready  in  1  fetch accepts redirect
- o_flush  out  1  one-cycle pulse on trap accept, kills younger stages

## Operation
- States: IDLE, REDIRECT. o_req_ready = (state==IDLE).
- Accept when i_req_valid & o_req_ready & take; take = irq_take | i_illegal_sel | i_ebreak_sel | i_ecall_sel | i_mret_sel.
- irq_take = mstatus.MIE & |(i_irq & mie[bits]); lowest-index-first is wrong: highest line index wins (external > timer > software).
- Priority: interrupt > illegal(2) > ebreak(3) > ecall(11) > mret. mret alongside any higher source is discarded.
- Trap entry (irq/exception): mepc ← {i_pc[PC_WD-1:1],0} zero-extended; mcause ← {irq, code}; MPIE ← MIE; MIE ← 0; target = exception ? BASE : (MODE==1 ? BASE + 4·code : BASE). BASE = {mtvec[CSR_WD-1:2],2'b00}; MODE = mtvec[1:0], values ≥2 treated as 0.
- mret: MIE ← MPIE; MPIE ← 1; target = mepc.
- CSRs: mstatus 0x300 (MIE bit 3, MPIE bit 7, MPP bits 12:11 read 2'b11, rest 0), mie 0x304, mtvec 0x305, mip 0x344 (read-only, reflects i_irq at 3/7/11/15), mepc 0x341 (bit 0 forced 0), mcause 0x342. Unknown address reads 0, writes ignored.
- CSR write and trap accept in same cycle: trap update wins for every field the trap writes; write lands on other fields.
- mie bits beyond IRQ_NUM read 0 and are not writable.

## Timing
- Accept in cycle N; CSRs update at edge ending N; o_flush high in N only (combinational from accept).
- o_redirect_valid and o_redirect_pc registered: high from N+1, held stable until i_redirect_ready; REDIRECT→IDLE on the handshake edge; earliest next accept at that next cycle.
- i_irq changes while in REDIRECT do not alter the pending redirect.
- Reset (any time, including mid-REDIRECT): state IDLE, o_redirect_valid 0, o_redirect_pc 0, o_flush 0, mstatus MIE/MPIE 0, mie 0, mepc 0, mcause 0, mtvec MTVEC_RST. o_req_ready 1 after reset.
- o_csr_rdata reflects state before the current edge (no write bypass).

## Structure
- Package ysyx_22050710_trap_pkg: CSR address constants, exception cause codes, IRQ code function (4k+3), state enum, mstatus bit positions.
- One sub-module ysyx_22050710_irq_arbiter: masks i_irq with mie/MIE, outputs irq_take and winning code.

## Test plan
- Reset, mtvec=0x8000_0000 direct, i_ecall_sel at pc 0x8000_0100 -> flush pulse, redirect 0x8000_0000 next cycle, mepc 0x8000_0100, mcause 11, MIE 0.
- Then mret with ready held low 3 cycles -> redirect 0x8000_0100 stable 3 cycles, o_req_ready 0 throughout, MIE restored from MPIE.
- mtvec=0x8000_0001, MIE=1, mie=0x888, i_irq=3'b110 -> cause 0x8..0B, redirect 0x8000_002C.
- Ecall with illegal both set -> mcause 2; mret with ecall -> mcause 11, no mret.
- CSR write mstatus=0x8 same cycle as ecall accept -> MIE 0, MPIE equals pre-edge MIE.
- Assert i_rst during REDIRECT -> o_redirect_valid 0 asynchronously, mtvec = MTVEC_RST.
